// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared types and constants for the instruction-fetch stage
package stage_if_pkg;

    typedef logic [31:0] inst_t;

    localparam inst_t       INST_NOP                   = 32'h0000_0013;
    localparam logic [31:0] CAUSE_INST_ADDR_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_INST_ACCESS_FAULT    = 32'd1;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    typedef enum logic [1:0] {
        TRAP_NONE   = 2'd0,
        TRAP_ENTER  = 2'd1,
        TRAP_RETURN = 2'd2
    } trap_kind_t;

    typedef struct packed {
        logic        valid;
        trap_kind_t  kind;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_req_t;

    // The tag holds the full PC so any BTB_ENTRIES setting works without retyping.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } bp_entry_t;

    typedef struct packed {
        logic stall_f;
    } hazard_res_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/hazard_interface.sv
// rtl/hazard_interface.sv - hazard unit to pipeline stage control bundle
interface hazard_interface;
    import stage_if_pkg::*;

    hazard_res_t res;

    modport requester (input res);
    modport unit (output res);

endinterface

// File: rtl/stage_if_branch_predictor.sv
// rtl/stage_if_branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters
module stage_if_branch_predictor
    import stage_if_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] lookup_pc,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    bp_entry_t        btb [BTB_ENTRIES];
    logic [IDX-1:0]   look_idx;
    logic [IDX-1:0]   upd_idx;
    logic             upd_hit;
    logic             upd_write;
    bp_entry_t        upd_new;

    assign look_idx = lookup_pc[IDX+1:2];
    assign upd_idx  = update_pc[IDX+1:2];

    // Reads come straight from the array, so a same-cycle update is not visible yet.
    assign lookup_taken  = btb[look_idx].valid && (btb[look_idx].tag == lookup_pc)
                           && btb[look_idx].ctr[1];
    assign lookup_target = btb[look_idx].target;

    assign upd_hit = btb[upd_idx].valid && (btb[upd_idx].tag == update_pc);

    always_comb begin
        upd_new   = btb[upd_idx];
        upd_write = 1'b0;
        if (update_valid) begin
            if (upd_hit) begin
                upd_write   = 1'b1;
                upd_new.ctr = ctr_next(btb[upd_idx].ctr, update_taken);
                if (update_taken) begin
                    upd_new.target = update_target;
                end
            end else if (update_taken) begin
                upd_write      = 1'b1;
                upd_new.valid  = 1'b1;
                upd_new.tag    = update_pc;
                upd_new.target = update_target;
                upd_new.ctr    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid  <= 1'b0;
                btb[i].tag    <= '0;
                btb[i].target <= '0;
                btb[i].ctr    <= CTR_RESET;
            end
        end else if (upd_write) begin
            btb[upd_idx] <= upd_new;
        end
    end

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction-fetch stage: PC register, imem drive, next-PC prediction
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_redirect_valid,
    input  logic [31:0] trap_redirect_pc,
    input  logic        bp_update_valid,
    input  logic [31:0] bp_update_pc,
    input  logic [31:0] bp_update_target,
    input  logic        bp_update_taken,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_fault,
    output logic [31:0] pc_f,
    output logic [31:0] pcplus4_f,
    output logic [31:0] pc_pred_f,
    output logic        pred_taken_f,
    output inst_t       inst_f,
    output trap_req_t   trap_req_f,
    hazard_interface.requester hazard_bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        fetch_vld_q;
    logic        hold_vld_q;
    inst_t       inst_hold_q;
    logic        stall;
    logic        redirect_any;
    logic        bp_taken;
    logic [31:0] bp_target;

    assign stall        = hazard_bus.res.stall_f;
    assign redirect_any = redirect_valid | trap_redirect_valid;

    assign pc_f      = pc_q;
    assign pcplus4_f = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign imem_en   = start & ~stall;

    stage_if_branch_predictor #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_bp (
        .clk           (clk),
        .resetn        (start),
        .lookup_pc     (pc_q),
        .lookup_taken  (bp_taken),
        .lookup_target (bp_target),
        .update_valid  (bp_update_valid),
        .update_pc     (bp_update_pc),
        .update_target (bp_update_target),
        .update_taken  (bp_update_taken)
    );

    assign pred_taken_f = bp_taken;
    assign pc_pred_f    = bp_taken ? bp_target : pcplus4_f;

    always_comb begin
        trap_req_f = '0;
        if (pc_q[1:0] != 2'b00) begin
            trap_req_f.valid = 1'b1;
            trap_req_f.kind  = TRAP_ENTER;
            trap_req_f.cause = CAUSE_INST_ADDR_MISALIGNED;
            trap_req_f.pc    = pc_q;
            trap_req_f.tval  = pc_q;
        end else if (imem_fault) begin
            trap_req_f.valid = 1'b1;
            trap_req_f.kind  = TRAP_ENTER;
            trap_req_f.cause = CAUSE_INST_ACCESS_FAULT;
            trap_req_f.pc    = pc_q;
            trap_req_f.tval  = pc_q;
        end
    end

    // A faulting PC parks here until the trap unit or EX steers us away.
    always_comb begin
        if (trap_redirect_valid) begin
            pc_next = trap_redirect_pc;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (stall || trap_req_f.valid) begin
            pc_next = pc_q;
        end else begin
            pc_next = pc_pred_f;
        end
    end

    assign inst_f = hold_vld_q  ? inst_hold_q :
                    fetch_vld_q ? imem_rdata  : INST_NOP;

    always_ff @(posedge clk) begin
        if (!start) begin
            pc_q        <= RESET_PC;
            fetch_vld_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            inst_hold_q <= INST_NOP;
        end else begin
            pc_q        <= pc_next;
            fetch_vld_q <= imem_en & ~redirect_any & ~trap_req_f.valid;
            // The imem output is not held across a stall, so capture what decode sees.
            if (redirect_any) begin
                hold_vld_q <= 1'b0;
            end else if (stall) begin
                if (!hold_vld_q) begin
                    inst_hold_q <= inst_f;
                    hold_vld_q  <= 1'b1;
                end
            end else begin
                hold_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - self-checking bench for stage_if with directed and randomized scenarios
module tb_stage_if;
    import stage_if_pkg::*;

    logic        clk = 1'b0;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_redirect_valid;
    logic [31:0] trap_redirect_pc;
    logic        bp_update_valid;
    logic [31:0] bp_update_pc;
    logic [31:0] bp_update_target;
    logic        bp_update_taken;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_fault;
    logic [31:0] pc_f;
    logic [31:0] pcplus4_f;
    logic [31:0] pc_pred_f;
    logic        pred_taken_f;
    inst_t       inst_f;
    trap_req_t   trap_req_f;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_interface hz ();
    assign hz.res = hazard_res_t'(stall);

    stage_if dut (
        .clk                 (clk),
        .start               (start),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .trap_redirect_valid (trap_redirect_valid),
        .trap_redirect_pc    (trap_redirect_pc),
        .bp_update_valid     (bp_update_valid),
        .bp_update_pc        (bp_update_pc),
        .bp_update_target    (bp_update_target),
        .bp_update_taken     (bp_update_taken),
        .imem_en             (imem_en),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .imem_fault          (imem_fault),
        .pc_f                (pc_f),
        .pcplus4_f           (pcplus4_f),
        .pc_pred_f           (pc_pred_f),
        .pred_taken_f        (pred_taken_f),
        .inst_f              (inst_f),
        .trap_req_f          (trap_req_f),
        .hazard_bus          (hz)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Synchronous instruction memory; addresses at or above 0x8000 are unmapped.
    always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);
    assign imem_fault = (imem_addr >= 32'h0000_8000);

    task automatic cyc();
        @(negedge clk);
        redirect_valid      = 1'b0;
        trap_redirect_valid = 1'b0;
        bp_update_valid     = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stall = 1'b0;
        repeat (3) cyc();
        cyc();
        start = 1'b1;
    endtask

    task automatic bp_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        bp_update_valid  = 1'b1;
        bp_update_pc     = pc;
        bp_update_target = tgt;
        bp_update_taken  = tk;
    endtask

    task automatic test_reset();
        start = 1'b0;
        stall = 1'b0;
        cyc(); #1;
        n_vec++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL reset_imem_en: got %b want 0", imem_en); end
        n_vec++; if (pc_f !== 32'h0) begin n_err++; $display("FAIL reset_pc_in_reset: got %h want 00000000", pc_f); end
        cyc(); cyc(); cyc();
        start = 1'b1; #1;
        n_vec++; if (pc_f !== 32'h0) begin n_err++; $display("FAIL reset_pc0: got %h want 00000000", pc_f); end
        n_vec++; if (inst_f !== INST_NOP) begin n_err++; $display("FAIL reset_inst_nop: got %h want %h", inst_f, INST_NOP); end
        n_vec++; if (trap_req_f.valid !== 1'b0) begin n_err++; $display("FAIL reset_trap: got %b want 0", trap_req_f.valid); end
        n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL reset_pred0: got %b want 0", pred_taken_f); end
        n_vec++; if (pcplus4_f !== 32'h4) begin n_err++; $display("FAIL reset_pcplus4: got %h want 00000004", pcplus4_f); end
        cyc(); #1;
        n_vec++; if (pc_f !== 32'h4) begin n_err++; $display("FAIL reset_pc1: got %h want 00000004", pc_f); end
        n_vec++; if (inst_f !== mem_word(32'h0)) begin n_err++; $display("FAIL reset_inst1: got %h want %h", inst_f, mem_word(32'h0)); end
        cyc(); #1;
        n_vec++; if (pc_f !== 32'h8) begin n_err++; $display("FAIL reset_pc2: got %h want 00000008", pc_f); end
        n_vec++; if (inst_f !== mem_word(32'h4)) begin n_err++; $display("FAIL reset_inst2: got %h want %h", inst_f, mem_word(32'h4)); end
        n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL reset_pred2: got %b want 0", pred_taken_f); end
    endtask

    task automatic test_predictor();
        do_reset();
        bp_upd(32'h10, 32'h40, 1'b1); #1;
        repeat (4) cyc();
        #1;
        n_vec++; if (pc_f !== 32'h10) begin n_err++; $display("FAIL bp_pc10: got %h want 00000010", pc_f); end
        n_vec++; if (pred_taken_f !== 1'b1) begin n_err++; $display("FAIL bp_taken: got %b want 1", pred_taken_f); end
        n_vec++; if (pc_pred_f !== 32'h40) begin n_err++; $display("FAIL bp_target: got %h want 00000040", pc_pred_f); end
        cyc(); bp_upd(32'h10, 32'h40, 1'b0); #1;
        n_vec++; if (pc_f !== 32'h40) begin n_err++; $display("FAIL bp_follow: got %h want 00000040", pc_f); end
        cyc(); bp_upd(32'h10, 32'h40, 1'b0); redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
        cyc(); #1;
        n_vec++; if (pc_f !== 32'h10) begin n_err++; $display("FAIL bp_redir: got %h want 00000010", pc_f); end
        n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL bp_nt_after2: got %b want 0", pred_taken_f); end
        n_vec++; if (pc_pred_f !== 32'h14) begin n_err++; $display("FAIL bp_nt_pred: got %h want 00000014", pc_pred_f); end
        // Saturation: four taken updates cap at 3, so one not-taken still predicts taken.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            bp_upd(32'h20, 32'h80, (i < 4));
        end
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h20;
        cyc(); bp_upd(32'h20, 32'h80, 1'b0); #1;
        n_vec++; if (pred_taken_f !== 1'b1) begin n_err++; $display("FAIL bp_saturate: got %b want 1", pred_taken_f); end
        n_vec++; if (pc_pred_f !== 32'h80) begin n_err++; $display("FAIL bp_sat_tgt: got %h want 00000080", pc_pred_f); end
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
        n_vec++; if (pc_f !== 32'h80) begin n_err++; $display("FAIL bp_sat_follow: got %h want 00000080", pc_f); end
        cyc(); #1;
        n_vec++; if (pred_taken_f !== 1'b0) begin n_err++; $display("FAIL bp_sat_down: got %b want 0", pred_taken_f); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #1;
            n_vec++; if (pc_f !== 32'hC) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 0000000c", i, pc_f); end
            n_vec++; if (inst_f !== mem_word(32'h8)) begin n_err++; $display("FAIL stall_inst[%0d]: got %h want %h", i, inst_f, mem_word(32'h8)); end
            n_vec++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL stall_en[%0d]: got %b want 0", i, imem_en); end
        end
        cyc(); stall = 1'b0; #1;
        n_vec++; if (inst_f !== mem_word(32'h8)) begin n_err++; $display("FAIL stall_release_inst: got %h want %h", inst_f, mem_word(32'h8)); end
        n_vec++; if (pc_f !== 32'hC) begin n_err++; $display("FAIL stall_release_pc: got %h want 0000000c", pc_f); end
        cyc(); #1;
        n_vec++; if (inst_f !== mem_word(32'hC)) begin n_err++; $display("FAIL stall_after_inst: got %h want %h", inst_f, mem_word(32'hC)); end
        n_vec++; if (pc_f !== 32'h10) begin n_err++; $display("FAIL stall_after_pc: got %h want 00000010", pc_f); end
        cyc(); stall = 1'b1;
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h80;
        cyc(); stall = 1'b0; #1;
        n_vec++; if (pc_f !== 32'h80) begin n_err++; $display("FAIL stall_redir_pc: got %h want 00000080", pc_f); end
        n_vec++; if (inst_f !== INST_NOP) begin n_err++; $display("FAIL stall_redir_nop: got %h want %h", inst_f, INST_NOP); end
        cyc(); #1;
        n_vec++; if (inst_f !== mem_word(32'h80)) begin n_err++; $display("FAIL stall_redir_inst: got %h want %h", inst_f, mem_word(32'h80)); end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        trap_redirect_valid = 1'b1; trap_redirect_pc = 32'h200;
        stall = 1'b1;
        cyc(); stall = 1'b0; #1;
        n_vec++; if (pc_f !== 32'h200) begin n_err++; $display("FAIL prio_pc: got %h want 00000200", pc_f); end
        n_vec++; if (inst_f !== INST_NOP) begin n_err++; $display("FAIL prio_nop: got %h want %h", inst_f, INST_NOP); end
        cyc(); #1;
        n_vec++; if (inst_f !== mem_word(32'h200)) begin n_err++; $display("FAIL prio_latency: got %h want %h", inst_f, mem_word(32'h200)); end
        n_vec++; if (pc_f !== 32'h204) begin n_err++; $display("FAIL prio_pc_next: got %h want 00000204", pc_f); end
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cyc(); #1;
        n_vec++; if (trap_req_f.valid !== 1'b1) begin n_err++; $display("FAIL mis_valid: got %b want 1", trap_req_f.valid); end
        n_vec++; if (trap_req_f.kind !== TRAP_ENTER) begin n_err++; $display("FAIL mis_kind: got %0d want %0d", trap_req_f.kind, TRAP_ENTER); end
        n_vec++; if (trap_req_f.cause !== CAUSE_INST_ADDR_MISALIGNED) begin n_err++; $display("FAIL mis_cause: got %h want %h", trap_req_f.cause, CAUSE_INST_ADDR_MISALIGNED); end
        n_vec++; if (trap_req_f.tval !== 32'h102) begin n_err++; $display("FAIL mis_tval: got %h want 00000102", trap_req_f.tval); end
        n_vec++; if (trap_req_f.pc !== 32'h102) begin n_err++; $display("FAIL mis_pc_field: got %h want 00000102", trap_req_f.pc); end
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h20; #1;
        n_vec++; if (pc_f !== 32'h102) begin n_err++; $display("FAIL mis_hold: got %h want 00000102", pc_f); end
        n_vec++; if (inst_f !== INST_NOP) begin n_err++; $display("FAIL mis_nop: got %h want %h", inst_f, INST_NOP); end
        cyc(); #1;
        n_vec++; if (pc_f !== 32'h20) begin n_err++; $display("FAIL mis_exit_pc: got %h want 00000020", pc_f); end
        n_vec++; if (trap_req_f.valid !== 1'b0) begin n_err++; $display("FAIL mis_exit_trap: got %b want 0", trap_req_f.valid); end
    endtask

    task automatic test_fault();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h8000;
        cyc(); #1;
        n_vec++; if (trap_req_f.valid !== 1'b1) begin n_err++; $display("FAIL flt_valid: got %b want 1", trap_req_f.valid); end
        n_vec++; if (trap_req_f.cause !== CAUSE_INST_ACCESS_FAULT) begin n_err++; $display("FAIL flt_cause: got %h want %h", trap_req_f.cause, CAUSE_INST_ACCESS_FAULT); end
        n_vec++; if (trap_req_f.tval !== 32'h8000) begin n_err++; $display("FAIL flt_tval: got %h want 00008000", trap_req_f.tval); end
        cyc(); #1;
        n_vec++; if (pc_f !== 32'h8000) begin n_err++; $display("FAIL flt_hold: got %h want 00008000", pc_f); end
        n_vec++; if (inst_f !== INST_NOP) begin n_err++; $display("FAIL flt_nop: got %h want %h", inst_f, INST_NOP); end
    endtask

    function automatic logic [31:0] rand_target();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return (32'($urandom_range(0, 255)) << 2) | 32'h2;
        if (r == 1) return 32'h8000 + (32'($urandom_range(0, 15)) << 2);
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    task automatic test_random();
        logic [31:0] m_pc;
        inst_t       m_deliv;
        logic        m_frz_v;
        inst_t       m_frz;
        logic        m_v   [16];
        logic [31:0] m_tag [16];
        logic [31:0] m_tgt [16];
        int          m_ctr [16];
        int          ix;
        logic        e_taken;
        logic [31:0] e_pred;
        inst_t       e_inst;
        trap_req_t   e_trap;
        logic        redir;

        for (int i = 0; i < 16; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_pc = 32'h0; m_deliv = INST_NOP; m_frz_v = 1'b0; m_frz = INST_NOP;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            if (k > 0) cyc();
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin redirect_valid = 1'b1; redirect_pc = rand_target(); end
            if ($urandom_range(0, 19) == 0) begin trap_redirect_valid = 1'b1; trap_redirect_pc = rand_target(); end
            if ($urandom_range(0, 2) == 0)
                bp_upd($urandom_range(0, 1) ? {m_pc[31:2], 2'b00} : 32'($urandom_range(0, 31)) << 2,
                       32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)));
            #1;
            ix      = int'((m_pc >> 2) % 16);
            e_taken = m_v[ix] && (m_tag[ix] == m_pc) && (m_ctr[ix] >= 2);
            e_pred  = e_taken ? m_tgt[ix] : m_pc + 32'd4;
            e_inst  = m_frz_v ? m_frz : m_deliv;
            e_trap  = '0;
            if (m_pc % 4 != 0) begin
                e_trap.valid = 1'b1; e_trap.kind = TRAP_ENTER; e_trap.cause = CAUSE_INST_ADDR_MISALIGNED;
                e_trap.pc = m_pc; e_trap.tval = m_pc;
            end else if (m_pc >= 32'h8000) begin
                e_trap.valid = 1'b1; e_trap.kind = TRAP_ENTER; e_trap.cause = CAUSE_INST_ACCESS_FAULT;
                e_trap.pc = m_pc; e_trap.tval = m_pc;
            end
            n_vec++; if (pc_f !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", k, pc_f, m_pc); end
            n_vec++; if (pred_taken_f !== e_taken) begin n_err++; $display("FAIL rnd_taken[%0d]: got %b want %b", k, pred_taken_f, e_taken); end
            n_vec++; if (pc_pred_f !== e_pred) begin n_err++; $display("FAIL rnd_pred[%0d]: got %h want %h", k, pc_pred_f, e_pred); end
            n_vec++; if (inst_f !== e_inst) begin n_err++; $display("FAIL rnd_inst[%0d]: got %h want %h", k, inst_f, e_inst); end
            n_vec++; if (trap_req_f !== e_trap) begin n_err++; $display("FAIL rnd_trap[%0d]: got %h want %h", k, trap_req_f, e_trap); end
            n_vec++; if (imem_en !== !stall) begin n_err++; $display("FAIL rnd_en[%0d]: got %b want %b", k, imem_en, !stall); end

            redir = redirect_valid || trap_redirect_valid;
            if (redir) m_frz_v = 1'b0;
            else if (stall) begin
                if (!m_frz_v) begin m_frz = e_inst; m_frz_v = 1'b1; end
            end else m_frz_v = 1'b0;
            m_deliv = (!stall && !redir && !e_trap.valid) ? mem_word(m_pc) : INST_NOP;
            if (bp_update_valid) begin
                ix = int'((bp_update_pc >> 2) % 16);
                if (m_v[ix] && m_tag[ix] == bp_update_pc) begin
                    m_ctr[ix] = bp_update_taken ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                                : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
                    if (bp_update_taken) m_tgt[ix] = bp_update_target;
                end else if (bp_update_taken) begin
                    m_v[ix] = 1'b1; m_tag[ix] = bp_update_pc; m_tgt[ix] = bp_update_target; m_ctr[ix] = 2;
                end
            end
            m_pc = trap_redirect_valid ? trap_redirect_pc :
                   redirect_valid      ? redirect_pc :
                   (stall || e_trap.valid) ? m_pc : e_pred;
        end
        stall = 1'b0;
    endtask

    initial begin
        start = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        trap_redirect_valid = 1'b0; trap_redirect_pc = '0;
        bp_update_valid = 1'b0; bp_update_pc = '0; bp_update_target = '0; bp_update_taken = 1'b0;
        test_reset();
        test_predictor();
        test_stall();
        test_redirect_priority();
        test_misaligned();
        test_fault();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
